input_flow_ctrl: RTL

- Parametrised successor of the main-FIFO input flow controller.
- Decides each cycle whether to pop the head word of the main FIFO and forward it toward NUM_VC virtual-channel FIFOs.
- Adds per-destination stalling (MODE=1), a resume hysteresis FSM, registered forwarding of the popped word with its VC id, bad-VC discard, and saturating pop/stall counters.
- Sits between the main FIFO and the VC demux.

---
 rtl/input_flow_pkg.sv | 18 +
 rtl/sat_counter.sv | 20 ++
 rtl/input_flow_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/input_flow_pkg.sv
// Shared types and constants for the main-FIFO input flow controller.
package input_flow_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HOLD   = 2'd1,
        RESUME = 2'd2
    } flow_state_e;

    localparam int MODE_GLOBAL = 0;
    localparam int MODE_PER_VC = 1;

    // Width of a VC id field; never narrower than one bit.
    function automatic int vc_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    // Count increments, stopping at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (clear) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/input_flow_ctrl.sv
// Main-FIFO input flow controller: decides each cycle whether to pop the
// head word, forwards it registered with its VC id, discards bad-VC words,
// and applies a resume hysteresis after any pause.
module input_flow_ctrl
    import input_flow_pkg::*;
#(
    parameter int NUM_VC     = 2,
    parameter int DATA_W     = 6,
    parameter int VC_SEL_LSB = 4,
    parameter int MODE       = 0,
    parameter int RESUME_DLY = 2,
    parameter int CNT_W      = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_VC-1:0]         fifo_pause,
    input  logic                      fifo_empty_main,
    input  logic [DATA_W-1:0]         main_head,
    output logic                      pop_main,
    output logic                      pop_b,
    output logic                      valid_out,
    output logic [DATA_W-1:0]         data_out,
    output logic [vc_w(NUM_VC)-1:0]   vc_out,
    output logic                      err_vc,
    output logic [CNT_W-1:0]          pop_cnt,
    output logic [CNT_W-1:0]          stall_cnt
);

    localparam int VC_W = vc_w(NUM_VC);
    localparam int RC_W = (RESUME_DLY > 1) ? $clog2(RESUME_DLY) : 1;
    localparam logic [VC_W:0] NUM_VC_X = (VC_W+1)'(NUM_VC);

    flow_state_e      state;
    logic [RC_W-1:0]  rcnt;
    logic [VC_W-1:0]  head_vc;
    logic             head_ok;
    logic             head_paused;
    logic             blocked;
    logic             pop;

    assign head_vc = main_head[VC_SEL_LSB +: VC_W];
    assign head_ok = ({1'b0, head_vc} < NUM_VC_X);

    // Look up the pause of the head word's destination without indexing out of range.
    always_comb begin
        head_paused = 1'b0;
        for (int i = 0; i < NUM_VC; i++) begin
            if (head_vc == VC_W'(i)) begin
                head_paused = fifo_pause[i];
            end
        end
    end

    // A bad VC id never blocks in per-VC mode; it is popped and discarded.
    assign blocked = (MODE == MODE_GLOBAL) ? (|fifo_pause)
                   : (!fifo_empty_main && head_ok && head_paused);

    assign pop      = !reset && (state == RUN) && !fifo_empty_main && !blocked;
    assign pop_main = pop;
    assign pop_b    = pop;

    // Resume hysteresis: pops restart only after the pause stays low for the full window.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            rcnt  <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (blocked) state <= HOLD;
                end
                HOLD: begin
                    if (!blocked) begin
                        if (RESUME_DLY == 0) begin
                            state <= RUN;
                        end else begin
                            state <= RESUME;
                            rcnt  <= RC_W'(RESUME_DLY - 1);
                        end
                    end
                end
                RESUME: begin
                    if (blocked) begin
                        state <= HOLD;
                    end else if (rcnt == '0) begin
                        state <= RUN;
                    end else begin
                        rcnt <= rcnt - RC_W'(1);
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    // Forward the popped word one cycle later; bad-VC words only raise err_vc.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out <= 1'b0;
            err_vc    <= 1'b0;
            data_out  <= '0;
            vc_out    <= '0;
        end else begin
            valid_out <= pop && head_ok;
            err_vc    <= pop && !head_ok;
            if (pop && head_ok) begin
                data_out <= main_head;
                vc_out   <= head_vc;
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_pop_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (pop),
        .cnt   (pop_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (!fifo_empty_main && !pop),
        .cnt   (stall_cnt)
    );

endmodule
